// File: rtl/poly_store_arbiter.sv
// Round-robin arbiter for two requesters sharing one polynomial store.
// Sequences a whole-polynomial write or read per grant; strobes decode from registered state only.
module poly_store_arbiter #(
  parameter int N    = 8,
  parameter int logN = 3,
  parameter int b    = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [1:0]   op,
  input  logic [b-1:0] wr_data0,
  input  logic [b-1:0] wr_data1,
  output logic [1:0]   gnt,
  output logic         wr_pull,
  output logic         rd_valid,
  output logic [b-1:0] rd_data,
  output logic [1:0]   done,
  output logic [1:0]   err,
  output logic         busy,
  output logic         ps_reset,
  output logic         ps_WRITE,
  output logic         ps_data_in_ready,
  output logic         ps_READ,
  output logic [b-1:0] ps_data_in,
  input  logic [b-1:0] ps_data_out,
  input  logic         ps_data_out_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  localparam logic [logN:0] CNT_LAST = (logN+1)'(N);

  state_t        state_reg, state_next;
  logic [logN:0] cnt_reg, cnt_next;
  logic          ptr_reg, ptr_next;
  logic [1:0]    gnt_reg, gnt_next;
  logic          op_reg, op_next;
  logic [1:0]    err_reg, err_next;
  logic [1:0]    rst_sync_reg;
  logic          win;
  logic [b-1:0]  wr_data [2];
  logic [b-1:0]  din_term [2];

  // Pointer holder wins if it is requesting, otherwise the other requester.
  assign win = req[ptr_reg] ? ptr_reg : ~ptr_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= 1'b0;
      gnt_reg   <= '0;
      op_reg    <= 1'b0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      op_reg    <= op_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    op_next    = op_reg;
    err_next   = '0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          if (!op[win] && !ps_data_out_ready) begin
            err_next = win ? 2'b10 : 2'b01;
            ptr_next = ~win;
          end else begin
            gnt_next   = win ? 2'b10 : 2'b01;
            op_next    = op[win];
            cnt_next   = '0;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: state_next = XFER;
      XFER: begin
        if (cnt_reg == CNT_LAST) state_next = DONE;
        else                     cnt_next   = cnt_reg + 1'b1;
      end
      DONE: begin
        gnt_next   = '0;
        ptr_next   = gnt_reg[0];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset release is delayed two edges so the store sees a clean synchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_reg <= 2'b11;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b0};
  end

  assign wr_data[0] = wr_data0;
  assign wr_data[1] = wr_data1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign done[gi]     = (state_reg == DONE) && gnt_reg[gi];
      assign din_term[gi] = gnt_reg[gi] ? wr_data[gi] : '0;
    end
  endgenerate

  assign ps_data_in       = din_term[0] | din_term[1];
  assign ps_WRITE         = (state_reg == ISSUE) && op_reg;
  assign ps_data_in_ready = (state_reg == ISSUE) && op_reg;
  assign ps_READ          = (state_reg == ISSUE) && !op_reg;
  assign wr_pull          = (state_reg == XFER) && op_reg && (cnt_reg != CNT_LAST);
  assign rd_valid         = (state_reg == XFER) && !op_reg && (cnt_reg != '0);
  assign busy             = (state_reg != IDLE);
  assign gnt              = gnt_reg;
  assign err              = err_reg;
  assign rd_data          = ps_data_out;
  assign ps_reset         = rst_sync_reg[1];

endmodule

// File: doc/poly_store_arbiter.md
POLY_STORE_ARBITER -- requirements
Module: poly_store_arbiter

Interface
REQ-001 Parameter N, default 8, coefficients per polynomial.
REQ-002 Parameter logN, default 3, log2(N).
REQ-003 Parameter b, default 5, coefficient width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  2  per-requester transaction request, level, held until done/err.
REQ-007 op  input  2  per-requester operation: 1 = write polynomial, 0 = read polynomial.
REQ-008 wr_data0, wr_data1  input  b each  write coefficient from requester 0 / 1.
REQ-009 gnt  output  2  one-hot grant to the owning requester, high from ISSUE through DONE.
REQ-010 wr_pull  output  1  write beat strobe; granted requester presents next coefficient this cycle.
REQ-011 rd_valid  output  1  read beat strobe; rd_data holds a valid coefficient this cycle.
REQ-012 rd_data  output  b  direct copy of ps_data_out.
REQ-013 done  output  2  one-cycle completion pulse per requester.
REQ-014 err  output  2  one-cycle pulse: read requested while store empty.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 ps_reset  output  1  active-high synchronous reset for the polynomial store.
REQ-017 ps_WRITE, ps_data_in_ready, ps_READ  output  1 each  store command strobes.
REQ-018 ps_data_in  output  b  wr_data of granted requester (combinational mux by gnt); 0 when no grant.
REQ-019 ps_data_out  input  b  store output coefficient (lowest symbol).
REQ-020 ps_data_out_ready  input  1  store holds a complete polynomial.

Function
REQ-021 FSM states IDLE, ISSUE, XFER, DONE; 2-bit state register, beat counter cnt of logN+1 bits.
REQ-022 IDLE: round-robin among asserted req bits; priority pointer starts at requester 0; winner = pointer if requesting, else the other.
REQ-023 IDLE winner with op=0 and ps_data_out_ready=0: err[winner] pulses next cycle, pointer moves to the other requester, stay IDLE.
REQ-024 IDLE valid winner: gnt registered to winner, op latched, cnt<=0, next state ISSUE.
REQ-025 ISSUE (exactly one cycle, cycle A): write -> ps_WRITE=1 and ps_data_in_ready=1; read -> ps_READ=1; then XFER.
REQ-026 XFER lasts N+1 cycles (A+1..A+N+1), cnt increments each cycle, exits to DONE when cnt==N.
REQ-027 Write: wr_pull=1 in XFER cycles A+1..A+N (cnt 0..N-1); coefficient k is taken at cycle A+1+k; cycle A+N+1 is completion, wr_pull=0.
REQ-028 Read: rd_valid=0 at A+1; rd_valid=1 at A+2..A+N+1 (cnt 1..N); rd_data carries coefficient k at cycle A+2+k.
REQ-029 DONE (cycle A+N+2): done[gnt]=1 for one cycle, gnt cleared, pointer moves to the requester not just served, next state IDLE.
REQ-030 Transaction period: write or read occupies N+3 cycles from IDLE decision to return to IDLE; no pipelining or overlap.
REQ-031 Requests are not queued; req changes during ISSUE/XFER/DONE are ignored; req dropped before grant is withdrawn.
REQ-032 Both requesters asserting simultaneously: pointer holder served first, other served on next IDLE.
REQ-033 Strobes ps_WRITE, ps_data_in_ready, ps_READ, wr_pull, rd_valid, done, err decode from registered state/cnt only; no combinational path from req/op.
REQ-034 ps_data_out_ready is sampled only in IDLE.

Reset
REQ-035 reset low: state=IDLE, cnt=0, pointer=0, gnt=0, all strobes/done/err=0, busy=0, ps_reset=1, immediately and asynchronously.
REQ-036 ps_reset released through a 2-flop synchronizer: deasserts on second rising clk edge after reset rises, so the store always sees a synchronous reset edge.
REQ-037 Reset mid-transaction aborts it with no done pulse; store is cleared via ps_reset; following reads return err until a write completes.

Verification
REQ-038 Write by requester 0 (coefficients 1..8) after reset: ps_WRITE at A, wr_pull A+1..A+8, done[0] at A+10, ps_data_out_ready=1 by A+10.
REQ-039 Read by requester 1 after REQ-038: rd_valid A+2..A+9 with rd_data 1,2,...,8 in order, done[1] at A+10.
REQ-040 Read request on empty store after reset: err pulse on that requester next cycle, no ps_READ, busy stays 0.
REQ-041 req=2'b11 both writes, pointer=0: requester 0 served first, requester 1 granted in the IDLE following done[0]; next contention grants requester 0.
REQ-042 reset asserted at cnt=4 of a write: all outputs clear same cycle, ps_reset high through 2 edges after release, subsequent read -> err.
REQ-043 req/op toggled during XFER: no effect on gnt, strobes or cycle count.
